hazard_ctrl: RTL and testbench

//  Stall/flush/forward controller for the 5-stage MIPS pipeline; sequences PC, IF2ID and ID2EX.

---
 rtl/mips_pkg.sv | 17 +
 rtl/md_busy_counter.sv | 44 ++++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline hazard logic: forward selects,
// the "operand not used" Tuse code and default HI/LO unit latencies.
package mips_pkg;

    // Operand source selects. The EX-stage mux uses only the RF/latch, M and W codes.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Tuse value meaning the instruction never reads this source
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_busy_counter.sv
// Busy tracker for the multi-cycle HI/LO multiply/divide unit.
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_is_div_i,
    output logic md_busy_o
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    logic [3:0] md_cnt_q, md_cnt_d;

    // Load on a start into an idle unit; a start while counting is dropped
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_i && (md_cnt_q == 4'd0)) begin
            md_cnt_d = md_is_div_i ? DivLoad : MultLoad;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // The start cycle itself counts as busy so a HI/LO reader in ID stalls at once
    always_comb begin
        md_busy_o = md_start_i || (md_cnt_q != 4'd0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage MIPS pipeline.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [1:0]  tuse_rs_d,
    input  logic [1:0]  tuse_rt_d,
    input  logic        md_use_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  a3_e,
    input  logic [4:0]  a3_m,
    input  logic [4:0]  a3_w,
    input  logic [1:0]  tnew_e,
    input  logic [1:0]  tnew_m,
    input  logic        md_start_e,
    input  logic        md_is_div_e,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_clr,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic        stall_rs, stall_rt, stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk         (clk),
        .reset       (reset),
        .md_start_i  (md_start_e),
        .md_is_div_i (md_is_div_e),
        .md_busy_o   (md_busy)
    );

    // Stall when a producer in EX/MEM finishes later than the ID consumer needs it
    always_comb begin
        stall_rs = (rs_d != 5'd0) &&
                   (((rs_d == a3_e) && (tnew_e > tuse_rs_d)) ||
                    ((rs_d == a3_m) && (tnew_m > tuse_rs_d)));
        stall_rt = (rt_d != 5'd0) &&
                   (((rt_d == a3_e) && (tnew_e > tuse_rt_d)) ||
                    ((rt_d == a3_m) && (tnew_m > tuse_rt_d)));
        stall    = stall_rs || stall_rt || (md_use_d && md_busy);
        pc_en    = !stall;
        ifid_en  = !stall;
        idex_clr = stall;
    end

    // ID operand forwarding: nearest ready producer wins (EX > MEM > WB)
    always_comb begin
        fwd_rs_d = FWD_RF;
        if (rs_d != 5'd0) begin
            if ((rs_d == a3_e) && (tnew_e == 2'd0)) begin
                fwd_rs_d = FWD_E;
            end else if ((rs_d == a3_m) && (tnew_m == 2'd0)) begin
                fwd_rs_d = FWD_M;
            end else if (rs_d == a3_w) begin
                fwd_rs_d = FWD_W;
            end
        end
        fwd_rt_d = FWD_RF;
        if (rt_d != 5'd0) begin
            if ((rt_d == a3_e) && (tnew_e == 2'd0)) begin
                fwd_rt_d = FWD_E;
            end else if ((rt_d == a3_m) && (tnew_m == 2'd0)) begin
                fwd_rt_d = FWD_M;
            end else if (rt_d == a3_w) begin
                fwd_rt_d = FWD_W;
            end
        end
    end

    // EX operand forwarding: MEM (when ready) > WB > ID2EX latch
    always_comb begin
        fwd_rs_e = FWD_RF;
        if (rs_e != 5'd0) begin
            if ((rs_e == a3_m) && (tnew_m == 2'd0)) begin
                fwd_rs_e = FWD_M;
            end else if (rs_e == a3_w) begin
                fwd_rs_e = FWD_W;
            end
        end
        fwd_rt_e = FWD_RF;
        if (rt_e != 5'd0) begin
            if ((rt_e == a3_m) && (tnew_m == 2'd0)) begin
                fwd_rt_e = FWD_M;
            end else if (rt_e == a3_w) begin
                fwd_rt_e = FWD_W;
            end
        end
    end

    // Stall cycle counter, free-running wrap at 2^32
    always_comb begin
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
        stall_cnt   = stall_cnt_q;
    end

    // Stall counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences
// and a randomized run against a behavioural reference model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs_d;
        logic [4:0] rt_d;
        logic [1:0] tuse_rs_d;
        logic [1:0] tuse_rt_d;
        logic       md_use_d;
        logic [4:0] rs_e;
        logic [4:0] rt_e;
        logic [4:0] a3_e;
        logic [4:0] a3_m;
        logic [4:0] a3_w;
        logic [1:0] tnew_e;
        logic [1:0] tnew_m;
        logic       md_start_e;
        logic       md_is_div_e;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic       stall;
        logic [1:0] frd;
        logic [1:0] frt;
        logic [1:0] fre;
        logic [1:0] fte;
    } vec_t;

    logic        clk, reset;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, a3_e, a3_m, a3_w;
    logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic        md_use_d, md_start_e, md_is_div_e;
    logic        pc_en, ifid_en, idex_clr, md_busy;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt;

    int          n_total = 0;
    int          n_pass  = 0;
    in_t         cur;
    int          m_busy_left;
    logic [31:0] m_stall_cnt;

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .tuse_rs_d   (tuse_rs_d),
        .tuse_rt_d   (tuse_rt_d),
        .md_use_d    (md_use_d),
        .rs_e        (rs_e),
        .rt_e        (rt_e),
        .a3_e        (a3_e),
        .a3_m        (a3_m),
        .a3_w        (a3_w),
        .tnew_e      (tnew_e),
        .tnew_m      (tnew_m),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_clr    (idex_clr),
        .fwd_rs_d    (fwd_rs_d),
        .fwd_rt_d    (fwd_rt_d),
        .fwd_rs_e    (fwd_rs_e),
        .fwd_rt_e    (fwd_rt_e),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic in_t idle_in();
        in_t x = '0;
        x.tuse_rs_d = 2'd3;
        x.tuse_rt_d = 2'd3;
        return x;
    endfunction

    task automatic drive(input in_t x);
        cur         = x;
        rs_d        = x.rs_d;
        rt_d        = x.rt_d;
        tuse_rs_d   = x.tuse_rs_d;
        tuse_rt_d   = x.tuse_rt_d;
        md_use_d    = x.md_use_d;
        rs_e        = x.rs_e;
        rt_e        = x.rt_e;
        a3_e        = x.a3_e;
        a3_m        = x.a3_m;
        a3_w        = x.a3_w;
        tnew_e      = x.tnew_e;
        tnew_m      = x.tnew_m;
        md_start_e  = x.md_start_e;
        md_is_div_e = x.md_is_div_e;
    endtask

    // ---------------- reference model ----------------
    // A source needs data from a producer that is still too far from done.
    function automatic logic ref_late(input logic [4:0] src, input logic [1:0] tuse, input in_t x);
        logic [4:0] dst [2];
        int         ready_in [2];
        dst[0] = x.a3_e; ready_in[0] = int'(x.tnew_e);
        dst[1] = x.a3_m; ready_in[1] = int'(x.tnew_m);
        for (int k = 0; k < 2; k++) begin
            if (src != 0 && src == dst[k] && ready_in[k] > int'(tuse)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic ref_busy(input in_t x, input int busy_left);
        return x.md_start_e || busy_left > 0;
    endfunction

    function automatic logic ref_stall(input in_t x, input int busy_left);
        return ref_late(x.rs_d, x.tuse_rs_d, x) || ref_late(x.rt_d, x.tuse_rt_d, x) ||
               (x.md_use_d && ref_busy(x, busy_left));
    endfunction

    // Scan producers nearest-first from stage 'first' (0=EX,1=MEM,2=WB); select = stage+1
    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input int first, input in_t x);
        logic [4:0] dst [3];
        logic       rdy [3];
        dst[0] = x.a3_e; rdy[0] = (x.tnew_e == 0);
        dst[1] = x.a3_m; rdy[1] = (x.tnew_m == 0);
        dst[2] = x.a3_w; rdy[2] = 1'b1;
        for (int k = first; k < 3; k++) begin
            if (src != 0 && src == dst[k] && rdy[k]) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    task automatic check_model(input string tag);
        logic s;
        s = ref_stall(cur, m_busy_left);
        chk({tag, ".ctl"}, {29'd0, pc_en, ifid_en, idex_clr}, {29'd0, !s, !s, s});
        chk({tag, ".fwd"}, {24'd0, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e},
            {24'd0, ref_fwd(cur.rs_d, 0, cur), ref_fwd(cur.rt_d, 0, cur),
             ref_fwd(cur.rs_e, 1, cur), ref_fwd(cur.rt_e, 1, cur)});
        chk({tag, ".busy"}, {31'd0, md_busy}, {31'd0, ref_busy(cur, m_busy_left)});
        chk({tag, ".cnt"}, stall_cnt, m_stall_cnt);
    endtask

    task automatic tick();
        logic s;
        @(posedge clk);
        s = ref_stall(cur, m_busy_left);
        if (reset) begin
            m_busy_left = 0;
            m_stall_cnt = 0;
        end else begin
            if (s) m_stall_cnt = m_stall_cnt + 1;
            if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
            else if (cur.md_start_e) m_busy_left = cur.md_is_div_e ? 10 : 5;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(idle_in());
        tick();
        reset = 1'b0;
        #1;
    endtask

    vec_t vecs [10];

    initial begin
        in_t x;
        int  stalls, issue;
        m_busy_left = 0;
        m_stall_cnt = 0;
        reset = 1'b1;
        drive(idle_in());
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst.pc_en", {31'd0, pc_en}, 32'd1);
        chk("rst.ifid_en", {31'd0, ifid_en}, 32'd1);
        chk("rst.idex_clr", {31'd0, idex_clr}, 32'd0);
        chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);

        // Table: {rs_d,rt_d,tuse_rs,tuse_rt,md_use,rs_e,rt_e,a3_e,a3_m,a3_w,tnew_e,tnew_m,start,div}
        vecs[0] = '{i: '{0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, stall: 0, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[1] = '{i: '{8, 0, 1, 3, 0, 0, 0, 8, 0, 0, 2, 0, 0, 0}, stall: 1, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[2] = '{i: '{0, 9, 3, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0}, stall: 1, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[3] = '{i: '{31, 0, 0, 3, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0}, stall: 0, frd: 1, frt: 0, fre: 0, fte: 0};
        vecs[4] = '{i: '{4, 4, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0}, stall: 0, frd: 2, frt: 2, fre: 0, fte: 0};
        vecs[5] = '{i: '{6, 0, 1, 3, 0, 6, 7, 0, 7, 6, 0, 0, 0, 0}, stall: 0, frd: 3, frt: 0, fre: 3, fte: 2};
        vecs[6] = '{i: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0}, stall: 0, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[7] = '{i: '{0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, stall: 0, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[8] = '{i: '{10, 0, 3, 3, 0, 0, 0, 10, 0, 0, 2, 0, 0, 0}, stall: 0, frd: 0, frt: 0, fre: 0, fte: 0};
        vecs[9] = '{i: '{0, 0, 3, 3, 0, 12, 0, 0, 12, 12, 0, 1, 0, 0}, stall: 0, frd: 0, frt: 0, fre: 3, fte: 0};
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].i);
            #1;
            chk($sformatf("vec%0d.ctl", v), {29'd0, pc_en, ifid_en, idex_clr},
                {29'd0, !vecs[v].stall, !vecs[v].stall, vecs[v].stall});
            chk($sformatf("vec%0d.fwd", v), {24'd0, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e},
                {24'd0, vecs[v].frd, vecs[v].frt, vecs[v].fre, vecs[v].fte});
            tick();
        end

        // Load-use: one bubble, then the value is forwarded from MEM
        do_reset();
        x = idle_in(); x.rs_d = 8; x.tuse_rs_d = 1; x.a3_e = 8; x.tnew_e = 2;
        drive(x); #1;
        chk("lu.pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu.idex_clr", {31'd0, idex_clr}, 32'd1);
        tick();
        x = idle_in(); x.rs_d = 8; x.tuse_rs_d = 1; x.a3_m = 8; x.tnew_m = 1;
        drive(x); #1;
        chk("lu.stall_cnt", stall_cnt, 32'd1);
        chk("lu2.pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        x = idle_in(); x.rs_e = 8; x.a3_m = 8; x.tnew_m = 0;
        drive(x); #1;
        chk("lu2.fwd_rs_e", {30'd0, fwd_rs_e}, 32'd2);
        tick();

        // mult in EX with mflo in ID: stalls MULT_CYCLES+1 cycles
        do_reset();
        x = idle_in(); x.md_use_d = 1; x.md_start_e = 1;
        stalls = 0; issue = -1;
        for (int c = 0; c < 20 && issue < 0; c++) begin
            drive(x); #1;
            if (c < 6) chk($sformatf("mult.busy%0d", c), {31'd0, md_busy}, 32'd1);
            if (pc_en) issue = c;
            else stalls++;
            tick();
            x.md_start_e = 0;
        end
        chk("mult.stalls", stalls, 32'd6);
        chk("mult.issue", issue, 32'd6);
        chk("mult.stall_cnt", stall_cnt, 32'd6);

        // div interrupted by reset on its 4th busy cycle
        do_reset();
        x = idle_in(); x.md_use_d = 1; x.md_start_e = 1; x.md_is_div_e = 1;
        drive(x); tick();
        x.md_start_e = 0; x.md_is_div_e = 0;
        drive(x); tick();
        tick(); #1;
        chk("div.busy4", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("div.rst_busy", {31'd0, md_busy}, 32'd0);
        chk("div.rst_cnt", stall_cnt, 32'd0);

        // Zero register and jal/jr EX forwarding
        x = idle_in(); x.tuse_rs_d = 0;
        drive(x); #1;
        chk("zero.fwd", {30'd0, fwd_rs_d}, 32'd0);
        chk("zero.pc_en", {31'd0, pc_en}, 32'd1);
        x = idle_in(); x.rs_d = 31; x.tuse_rs_d = 0; x.a3_e = 31; x.tnew_e = 0;
        drive(x); #1;
        chk("jr.fwd", {30'd0, fwd_rs_d}, 32'd1);
        chk("jr.pc_en", {31'd0, pc_en}, 32'd1);
        tick();

        // MEM beats WB in EX; stall counter wraps
        x = idle_in(); x.rs_e = 5; x.a3_m = 5; x.tnew_m = 0; x.a3_w = 5;
        drive(x); #1;
        chk("prio.fwd_rs_e", {30'd0, fwd_rs_e}, 32'd2);
        tick();
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFF;
        x = idle_in(); x.rs_d = 8; x.tuse_rs_d = 1; x.a3_e = 8; x.tnew_e = 2;
        drive(x); tick(); #1;
        chk("wrap.stall_cnt", stall_cnt, 32'd0);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            x.rs_d        = 5'($urandom_range(0, 3));
            x.rt_d        = 5'($urandom_range(0, 3));
            x.tuse_rs_d   = 2'($urandom_range(0, 3));
            x.tuse_rt_d   = 2'($urandom_range(0, 3));
            x.md_use_d    = ($urandom_range(0, 3) == 0);
            x.rs_e        = 5'($urandom_range(0, 3));
            x.rt_e        = 5'($urandom_range(0, 3));
            x.a3_e        = 5'($urandom_range(0, 3));
            x.a3_m        = 5'($urandom_range(0, 3));
            x.a3_w        = 5'($urandom_range(0, 3));
            x.tnew_e      = 2'($urandom_range(0, 2));
            x.tnew_m      = 2'($urandom_range(0, 1));
            x.md_start_e  = ($urandom_range(0, 7) == 0);
            x.md_is_div_e = 1'($urandom_range(0, 1));
            reset         = ($urandom_range(0, 59) == 0);
            drive(x); #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
